// File: rtl/lut_layer_sched_pkg.sv
// Shared types and helpers for the LUT layer scheduler: FSM state encoding,
// index-width helper, default connectivity map and tt_addr field layout.
package lut_layer_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } sched_state_t;

    // Upper bound on the flattened connectivity map; unused upper bits are ignored.
    localparam int MAP_MAX_W = 1024;

    // tt_addr layout: fanin bits in the low field, neuron index directly above.
    localparam int TT_BITS_LSB = 0;

    // Width of an index into n items (at least one bit).
    function automatic int nidx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Bit position of the neuron-index field inside tt_addr.
    function automatic int tt_idx_lsb(input int fanin);
        return TT_BITS_LSB + fanin;
    endfunction

    // Default tap: neuron n, fanin slot k reads input bit (n*FANIN+k) mod IN_WIDTH.
    function automatic int conn_default(input int n, input int k, input int fanin,
                                        input int in_width);
        return (n * fanin + k) % in_width;
    endfunction

    // Flattened default map, entry (n*FANIN+k) at bit offset (n*FANIN+k)*SEL_W.
    function automatic logic [MAP_MAX_W-1:0] conn_map_default(input int num_neurons,
                                                              input int fanin,
                                                              input int in_width);
        logic [MAP_MAX_W-1:0] m;
        int sel_w;
        int tap;
        int pos;
        m     = '0;
        sel_w = nidx_w(in_width);
        for (int n = 0; n < num_neurons; n++) begin
            for (int k = 0; k < fanin; k++) begin
                tap = conn_default(n, k, fanin, in_width);
                pos = (n * fanin + k) * sel_w;
                m   = m | (MAP_MAX_W'(unsigned'(tap)) << pos);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/lut_fanin_gather.sv
// Combinational fanin gather: picks the FANIN input bits wired to neuron n
// out of the registered layer input, following the connectivity map.
module lut_fanin_gather
    import lut_layer_sched_pkg::*;
#(
    parameter int                   IN_WIDTH    = 16,
    parameter int                   NUM_NEURONS = 8,
    parameter int                   FANIN       = 6,
    parameter logic [MAP_MAX_W-1:0] CONN_MAP    = conn_map_default(NUM_NEURONS, FANIN, IN_WIDTH)
) (
    input  logic [IN_WIDTH-1:0]              in_reg,
    input  logic [nidx_w(NUM_NEURONS)-1:0]   n,
    output logic [FANIN-1:0]                 fanin_bits
);

    localparam int SEL_W  = nidx_w(IN_WIDTH);
    localparam int NIDX_W = nidx_w(NUM_NEURONS);

    logic [FANIN-1:0] taps [NUM_NEURONS];
    logic [FANIN-1:0] acc  [NUM_NEURONS+1];

    // Static wiring of every neuron's taps; a bad map entry stops elaboration.
    for (genvar g_n = 0; g_n < NUM_NEURONS; g_n++) begin : g_neuron
        for (genvar g_k = 0; g_k < FANIN; g_k++) begin : g_tap
            localparam int              POS = (g_n * FANIN + g_k) * SEL_W;
            localparam logic [SEL_W-1:0] TAP = CONN_MAP[POS +: SEL_W];
            if (int'(TAP) >= IN_WIDTH) begin : g_bad_tap
                $error("CONN_MAP entry for neuron %0d slot %0d is out of range", g_n, g_k);
            end
            assign taps[g_n][g_k] = in_reg[TAP];
        end
    end

    // AND-OR mux over neurons keeps the select free of out-of-range indices.
    assign acc[0] = '0;
    for (genvar g_n = 0; g_n < NUM_NEURONS; g_n++) begin : g_sel
        assign acc[g_n+1] = acc[g_n] | ((n == NIDX_W'(g_n)) ? taps[g_n] : '0);
    end

    assign fanin_bits = acc[NUM_NEURONS];

endmodule

// File: rtl/lut_layer_scheduler.sv
// Time-multiplexes one shared truth-table memory across all neurons of a
// LogicNets layer: accept a vector, issue one lookup per neuron, collect the
// 1-bit responses through a latency tracker, then hold the layer output.
module lut_layer_scheduler
    import lut_layer_sched_pkg::*;
#(
    parameter int                   IN_WIDTH    = 16,
    parameter int                   NUM_NEURONS = 8,
    parameter int                   FANIN       = 6,
    parameter int                   TT_LATENCY  = 1,
    parameter logic [MAP_MAX_W-1:0] CONN_MAP    = conn_map_default(NUM_NEURONS, FANIN, IN_WIDTH)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [IN_WIDTH-1:0]                    in_data,
    output logic                                   tt_en,
    output logic [nidx_w(NUM_NEURONS)+FANIN-1:0]   tt_addr,
    input  logic                                   tt_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [NUM_NEURONS-1:0]                 out_data,
    output logic                                   busy
);

    localparam int                NIDX_W   = nidx_w(NUM_NEURONS);
    localparam int                IDX_LSB  = tt_idx_lsb(FANIN);
    localparam logic [NIDX_W-1:0] LAST_IDX = NIDX_W'(NUM_NEURONS - 1);

    if (NUM_NEURONS < 2) begin : g_bad_neurons
        $error("NUM_NEURONS must be at least 2");
    end
    if (TT_LATENCY < 1 || TT_LATENCY > 4) begin : g_bad_latency
        $error("TT_LATENCY must be in 1..4");
    end
    if (NUM_NEURONS * FANIN * nidx_w(IN_WIDTH) > MAP_MAX_W) begin : g_bad_map
        $error("CONN_MAP does not fit in MAP_MAX_W bits");
    end

    sched_state_t                    state;
    sched_state_t                    state_nxt;
    logic [NIDX_W-1:0]               n_cnt;
    logic                            last_issue;
    logic [IN_WIDTH-1:0]             in_reg;
    logic [FANIN-1:0]                fanin_bits;
    logic [NUM_NEURONS-1:0]          out_reg;
    logic [TT_LATENCY-1:0]              trk_vld;
    logic [TT_LATENCY-1:0][NIDX_W-1:0]  trk_idx;
    logic [TT_LATENCY-1:0]              trk_vld_shift;
    logic [TT_LATENCY-1:0][NIDX_W-1:0]  trk_idx_shift;
    logic                            resp_vld;
    logic [NIDX_W-1:0]               resp_idx;
    logic                            last_resp;

    assign last_issue = (n_cnt == LAST_IDX);
    assign resp_vld   = trk_vld[TT_LATENCY-1];
    assign resp_idx   = trk_idx[TT_LATENCY-1];
    assign last_resp  = resp_vld && (resp_idx == LAST_IDX);

    lut_fanin_gather #(
        .IN_WIDTH    (IN_WIDTH),
        .NUM_NEURONS (NUM_NEURONS),
        .FANIN       (FANIN),
        .CONN_MAP    (CONN_MAP)
    ) u_gather (
        .in_reg     (in_reg),
        .n          (n_cnt),
        .fanin_bits (fanin_bits)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: accept, issue all neurons, wait for the last response, hold.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid && in_ready) state_nxt = ISSUE;
            ISSUE:   if (last_issue)           state_nxt = DRAIN;
            DRAIN:   if (last_resp)            state_nxt = HOLD;
            HOLD:    if (out_ready)            state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        in_ready  = 1'b0;
        tt_en     = 1'b0;
        tt_addr   = '0;
        out_valid = 1'b0;
        out_data  = out_reg;
        busy      = (state != IDLE);
        unique case (state)
            IDLE:  in_ready = !rst;
            ISSUE: begin
                tt_en                           = 1'b1;
                tt_addr[TT_BITS_LSB +: FANIN]   = fanin_bits;
                tt_addr[IDX_LSB +: NIDX_W]      = n_cnt;
            end
            HOLD:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Neuron issue counter: advances once per ISSUE cycle, returns to 0 after the last neuron.
    always_ff @(posedge clk) begin
        if (rst) n_cnt <= '0;
        else     n_cnt <= (state == ISSUE && !last_issue) ? n_cnt + 1'b1 : '0;
    end

    // Input vector register, loaded only on the input handshake.
    always_ff @(posedge clk) begin
        if (rst)                        in_reg <= '0;
        else if (in_valid && in_ready)  in_reg <= in_data;
    end

    // Tracker shift: stage 0 takes this cycle's issue, deeper stages age by one.
    assign trk_vld_shift[0] = tt_en;
    assign trk_idx_shift[0] = n_cnt;
    for (genvar g_s = 1; g_s < TT_LATENCY; g_s++) begin : g_trk
        assign trk_vld_shift[g_s] = trk_vld[g_s-1];
        assign trk_idx_shift[g_s] = trk_idx[g_s-1];
    end

    // Response tracker: (valid, idx) pairs aligned with the memory read latency.
    always_ff @(posedge clk) begin
        // NOTE: the tracker is cleared on reset because a stale valid bit would capture a late response.
        if (rst) begin
            trk_vld <= '0;
            trk_idx <= '0;
        end else begin
            trk_vld <= trk_vld_shift;
            trk_idx <= trk_idx_shift;
        end
    end

    // Output collection: tt_data lands in the neuron's bit only when its tracked entry emerges.
    always_ff @(posedge clk) begin
        if (rst)           out_reg <= '0;
        else if (resp_vld) out_reg[resp_idx] <= tt_data;
    end

endmodule

// File: tb/tb_lut_layer_scheduler.sv
// Scoreboard bench for lut_layer_scheduler: a default instance (TT_LATENCY=1)
// and a TT_LATENCY=3 instance, each with a popcount>=3 truth-table model.
module tb_lut_layer_scheduler;

    localparam int A_LAT = 1 + 8 + 1;
    localparam int B_LAT = 1 + 8 + 3;

    typedef struct {
        logic [7:0] data;
        int         hs_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic        a_in_valid = 1'b0, b_in_valid = 1'b0;
    logic        a_in_ready, b_in_ready;
    logic [15:0] a_in_data = '0, b_in_data = '0;
    logic        a_tt_en, b_tt_en;
    logic [8:0]  a_tt_addr, b_tt_addr;
    logic        a_tt_data, b_tt_data;
    logic        a_out_valid, b_out_valid;
    logic        a_out_ready = 1'b1, b_out_ready = 1'b1;
    logic [7:0]  a_out_data, b_out_data;
    logic        a_busy, b_busy;

    exp_t        a_q[$];
    exp_t        b_q[$];
    logic [8:0]  a_tt_log[$];
    int          a_rise = 0, b_rise = 0;
    int          a_out_hs_cyc = 0;

    lut_layer_scheduler u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .tt_en(a_tt_en), .tt_addr(a_tt_addr), .tt_data(a_tt_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .busy(a_busy)
    );

    lut_layer_scheduler #(.TT_LATENCY(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .tt_en(b_tt_en), .tt_addr(b_tt_addr), .tt_data(b_tt_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .busy(b_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Truth table: neuron fires iff at least 3 of its fanin bits are set.
    function automatic logic tt_fn(input logic [8:0] addr);
        return ($countones(addr[5:0]) >= 3);
    endfunction

    // Memory models; idle reads return 1 so unguarded captures show up.
    logic       a_mem_q = 1'b1;
    logic [2:0] b_mem_q = 3'b111;
    always @(posedge clk) begin
        a_mem_q <= a_tt_en ? tt_fn(a_tt_addr) : 1'b1;
        b_mem_q <= {b_mem_q[1:0], (b_tt_en ? tt_fn(b_tt_addr) : 1'b1)};
    end
    assign a_tt_data = a_mem_q;
    assign b_tt_data = b_mem_q[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor A: scoreboard pop, latency, hold stability, tt_addr quiet outside issue.
    logic       a_prev_valid = 1'b0, a_prev_hs = 1'b0;
    logic [7:0] a_prev_data = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            a_prev_valid = 1'b0;
            a_prev_hs    = 1'b0;
        end else begin
            if (a_out_valid && !a_prev_valid) a_rise = cyc;
            if (a_prev_hs) check("a_valid_drop", 32'(a_out_valid), 32'(0));
            if (a_out_valid) begin
                check("a_in_ready_in_hold", 32'(a_in_ready), 32'(0));
                if (a_prev_valid && !a_prev_hs)
                    check("a_hold_stable", 32'(a_out_data), 32'(a_prev_data));
            end
            if (a_tt_en) a_tt_log.push_back(a_tt_addr);
            else         check("a_tt_addr_idle", 32'(a_tt_addr), 32'(0));
            a_prev_hs = a_out_valid && a_out_ready;
            if (a_prev_hs) begin
                a_out_hs_cyc = cyc;
                if (a_q.size() == 0) begin
                    check("a_unexpected_out", 32'(a_q.size()), 32'(1));
                end else begin
                    e = a_q.pop_front();
                    check("a_out_data", 32'(a_out_data), 32'(e.data));
                    check("a_latency", 32'(a_rise - e.hs_cyc), 32'(A_LAT));
                end
            end
            a_prev_valid = a_out_valid;
            a_prev_data  = a_out_data;
        end
    end

    // Monitor B: scoreboard pop and latency for the TT_LATENCY=3 instance.
    logic b_prev_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            b_prev_valid = 1'b0;
        end else begin
            if (b_out_valid && !b_prev_valid) b_rise = cyc;
            if (b_out_valid && b_out_ready) begin
                if (b_q.size() == 0) begin
                    check("b_unexpected_out", 32'(b_q.size()), 32'(1));
                end else begin
                    e = b_q.pop_front();
                    check("b_out_data", 32'(b_out_data), 32'(e.data));
                    check("b_latency", 32'(b_rise - e.hs_cyc), 32'(B_LAT));
                end
            end
            b_prev_valid = b_out_valid;
        end
    end

    // Present one vector; record the handshake cycle and optionally the expected output.
    task automatic send(input bit sel_b, input logic [15:0] d, input logic [7:0] exp,
                        input bit push, output int hs);
        int   waited;
        logic rdy;
        exp_t e;
        waited = 0;
        hs     = -1;
        @(posedge clk); #1;
        if (sel_b) begin b_in_valid = 1'b1; b_in_data = d; end
        else       begin a_in_valid = 1'b1; a_in_data = d; end
        while (hs < 0 && waited < 200) begin
            @(negedge clk);
            rdy = sel_b ? b_in_ready : a_in_ready;
            if (rdy) hs = cyc;
            waited++;
        end
        check("in_handshake", 32'(hs >= 0), 32'(1));
        if (push && hs >= 0) begin
            e.data   = exp;
            e.hs_cyc = hs;
            if (sel_b) b_q.push_back(e);
            else       a_q.push_back(e);
        end
        @(posedge clk); #1;
        if (sel_b) b_in_valid = 1'b0;
        else       a_in_valid = 1'b0;
    endtask

    // Wait until the instance is idle and its scoreboard is drained.
    task automatic wait_idle(input bit sel_b);
        int  n;
        logic pending;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            pending = sel_b ? (b_busy || b_q.size() != 0) : (a_busy || a_q.size() != 0);
        end while (pending && n < 300);
        check("idle_reached", 32'(pending), 32'(0));
    endtask

    initial begin
        int hs, hs2, n;
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("in_ready_during_rst", 32'(a_in_ready), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  32'(a_in_ready),  32'(1));
        check("rst_out_valid", 32'(a_out_valid), 32'(0));
        check("rst_out_data",  32'(a_out_data),  32'(0));
        check("rst_tt_en",     32'(a_tt_en),     32'(0));
        check("rst_tt_addr",   32'(a_tt_addr),   32'(0));
        check("rst_busy",      32'(a_busy),      32'(0));

        // All ones: every neuron fires.
        a_tt_log.delete();
        send(1'b0, 16'hFFFF, 8'hFF, 1'b1, hs);
        wait_idle(1'b0);
        check("ffff_tt_en_cycles", 32'(a_tt_log.size()), 32'(8));

        // All zeros: address sequence {n, 000000}, eight reads.
        a_tt_log.delete();
        send(1'b0, 16'h0000, 8'h00, 1'b1, hs);
        wait_idle(1'b0);
        check("zero_tt_en_cycles", 32'(a_tt_log.size()), 32'(8));
        for (int i = 0; i < 8 && i < a_tt_log.size(); i++)
            check("zero_tt_addr", 32'(a_tt_log[i]), 32'(i << 6));

        // Low six bits: neurons 0, 3, 5 fire.
        send(1'b0, 16'h003F, 8'h29, 1'b1, hs);
        wait_idle(1'b0);

        // Backpressure: out_ready low for 5 HOLD cycles with the next vector waiting.
        a_out_ready = 1'b0;
        send(1'b0, 16'h003F, 8'h29, 1'b1, hs);
        a_in_valid = 1'b1;
        a_in_data  = 16'hFFFF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_out_valid && n < 50);
        check("bp_valid_seen", 32'(a_out_valid), 32'(1));
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", 32'(a_in_ready),  32'(0));
            check("bp_valid",    32'(a_out_valid), 32'(1));
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        send(1'b0, 16'hFFFF, 8'hFF, 1'b1, hs2);
        check("bp_next_after_out_hs", 32'(hs2 > a_out_hs_cyc), 32'(1));
        wait_idle(1'b0);

        // Reset in the 4th ISSUE cycle aborts the transaction.
        send(1'b0, 16'hFFFF, 8'hFF, 1'b0, hs);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy",      32'(a_busy),      32'(0));
        check("abort_out_valid", 32'(a_out_valid), 32'(0));
        check("abort_tt_en",     32'(a_tt_en),     32'(0));
        check("abort_out_data",  32'(a_out_data),  32'(0));
        check("abort_in_ready",  32'(a_in_ready),  32'(1));
        send(1'b0, 16'hFFFF, 8'hFF, 1'b1, hs);
        wait_idle(1'b0);

        // TT_LATENCY=3 instance.
        send(1'b1, 16'h003F, 8'h29, 1'b1, hs);
        wait_idle(1'b1);
        send(1'b1, 16'hFFFF, 8'hFF, 1'b1, hs);
        wait_idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
